preprocess_fmac_pipe: RTL
=========================

Name: preprocess_fmac_pipe

Overview:
Parametrised, pipelined operand preprocessor for the FMAC datapath. It takes NUM_OPS packed IEEE-754 operands of configurable format and disassembles each into sign, extended exponent and mantissa with the hidden bit. It classifies each operand (zero/inf/NaN/sNaN/denormal) and, if enabled, pre-normalises denormals using a leading-zero count. One registered stage with a valid/ready handshake, flush, and a tag passed through; it sits between the operand issue logic and the multiplier/aligner.

Parameters:
C_EXP_W, 8, exponent field width (≥2)
C_MANT_W, 23, stored fraction width (≥2)
NUM_OPS, 3, number of operand channels (1..4)
NORM_DEN, 1, 1 = normalise denormals via LZC; 0 = exponent forced to 1, mantissa unshifted
TAG_W, 4, width of sideband tag

Ports:
Clk_CI  in  1  clock
Rst_RBI  in  1  asynchronous active-low reset
Flush_SI  in  1  synchronous flush, clears the stage
In_valid_SI  in  1  input operands valid
In_ready_SO  out  1  stage can accept
Operands_DI  in  NUM_OPS*(1+C_EXP_W+C_MANT_W)  operand i at slice i, layout {sign,exp,frac}
Tag_DI  in  TAG_W  sideband tag
Out_valid_SO  out  1  outputs valid
Out_ready_SI  in  1  downstream accepts
Sign_DO  out  NUM_OPS  sign per operand
Exp_DO  out  NUM_OPS*(C_EXP_W+2)  signed two's-complement biased exponent per operand
Mant_DO  out  NUM_OPS*(C_MANT_W+1)  {hidden bit, fraction} per operand
Zero_SO / Inf_SO / NaN_SO / SNaN_SO / DeN_SO  out  NUM_OPS each  class flags per operand
Tag_DO  out  TAG_W  registered tag

Behaviour:
- Reset (Rst_RBI=0, async): Out_valid_SO=0; all data/flag/tag registers 0. Reset mid-transfer drops the held item.
- Handshake: In_ready_SO = ~Out_valid_SO | Out_ready_SI (combinational). Input is captured when In_valid_SI & In_ready_SO. Latency is 1 cycle. Full throughput with back-to-back transfers while Out_ready_SI=1.
- Out_valid_SO falls when Out_ready_SI=1 and no new capture occurs. While Out_valid_SO=1 & Out_ready_SI=0, all outputs hold stable and no input is accepted.
- Simultaneous drain and capture in the same cycle: new data replaces the old, and Out_valid_SO stays 1.
- Flush_SI=1: the next cycle has Out_valid_SO=0 and no capture that cycle, regardless of In_valid_SI. Flush has priority over capture. Data registers may keep stale values.
- Data registers load only on capture, with no enable toggling otherwise.
- Per operand, let E = exp field and F = frac:
  - Zero: E==0 & F==0. Outputs exp 0, mant 0.
  - DeN: E==0 & F!=0.
  - Inf: E==all-ones & F==0.
  - NaN: E==all-ones & F!=0. SNaN = NaN & F[MSB]==0.
  - Normal: exp = zero-extended E, mant = {1,F}. Inf/NaN use the same rule (exp = all-ones zero-extended).
  - DeN with NORM_DEN=0: exp = 1, mant = {0,F}.
  - DeN with NORM_DEN=1: lz = leading zeros of F (0..C_MANT_W-1), mant = {0,F} << (lz+1) so the hidden bit is 1, exp = -lz in two's complement on C_EXP_W+2 bits.
- Flags are mutually exclusive except SNaN ⊂ NaN. Exactly one of {Zero, DeN, Inf, NaN, normal} holds per operand.
- Channels are independent; no cross-operand logic.

Test Plan:
1. Reset then fp32, operand0=0x3F800000, Out_ready_SI=1 -> next cycle Out_valid_SO=1, Exp=0x07F, Mant=0x800000, all flags 0, Tag_DO=Tag_DI.
2. NORM_DEN=1, op=0x00000001 -> DeN=1, Mant=0x800000, Exp=0x3EA (-22). op=0x00400000 -> Mant=0x800000, Exp=0x000. Same ops with NORM_DEN=0 -> Exp=0x001, Mant=0x000001 / 0x400000.
3. Classes: 0x7F800000 -> Inf, Exp=0x0FF. 0x7F800001 -> NaN & SNaN. 0x7FC00000 -> NaN, SNaN=0. 0x80000000 -> Zero, Sign=1, Exp=0, Mant=0.
4. Backpressure: send A, hold Out_ready_SI=0 for 3 cycles -> In_ready_SO=0 and outputs stable with A. Raise Out_ready_SI with B valid -> B appears the next cycle, no bubble, A consumed once.
5. Flush with Out_valid_SO=1 and In_valid_SI=1 -> Out_valid_SO=0 next cycle, input not captured. Assert Rst_RBI low mid-stream -> Out_valid_SO=0 immediately (async).
6. Streaming 1000 random operands (all classes, NUM_OPS=3), random Out_ready_SI -> output sequence matches the reference model in order with no loss or duplication; repeat with C_EXP_W=5, C_MANT_W=10.

Source files
------------

// File: rtl/preprocess_fmac_pipe.sv
// Operand preprocessor for the FMAC datapath: splits packed IEEE-754 operands
// into sign / extended exponent / mantissa, classifies them, and registers the result.
module preprocess_fmac_pipe #(
   parameter int unsigned C_EXP_W  = 8,
   parameter int unsigned C_MANT_W = 23,
   parameter int unsigned NUM_OPS  = 3,
   parameter int unsigned NORM_DEN = 1,
   parameter int unsigned TAG_W    = 4
) (
   input  logic                                Clk_CI,
   input  logic                                Rst_RBI,
   input  logic                                Flush_SI,
   input  logic                                In_valid_SI,
   output logic                                In_ready_SO,
   input  logic [NUM_OPS*(1+C_EXP_W+C_MANT_W)-1:0] Operands_DI,
   input  logic [TAG_W-1:0]                    Tag_DI,
   output logic                                Out_valid_SO,
   input  logic                                Out_ready_SI,
   output logic [NUM_OPS-1:0]                  Sign_DO,
   output logic [NUM_OPS*(C_EXP_W+2)-1:0]      Exp_DO,
   output logic [NUM_OPS*(C_MANT_W+1)-1:0]     Mant_DO,
   output logic [NUM_OPS-1:0]                  Zero_SO,
   output logic [NUM_OPS-1:0]                  Inf_SO,
   output logic [NUM_OPS-1:0]                  NaN_SO,
   output logic [NUM_OPS-1:0]                  SNaN_SO,
   output logic [NUM_OPS-1:0]                  DeN_SO,
   output logic [TAG_W-1:0]                    Tag_DO
);

   localparam int unsigned OP_W    = 1 + C_EXP_W + C_MANT_W;
   localparam int unsigned EXP_OW  = C_EXP_W + 2;
   localparam int unsigned MANT_OW = C_MANT_W + 1;
   localparam int unsigned LZ_W    = $clog2(C_MANT_W + 1);

   logic [NUM_OPS-1:0]         w_sign;
   logic [NUM_OPS*EXP_OW-1:0]  w_exp;
   logic [NUM_OPS*MANT_OW-1:0] w_mant;
   logic [NUM_OPS-1:0]         w_zero;
   logic [NUM_OPS-1:0]         w_inf;
   logic [NUM_OPS-1:0]         w_nan;
   logic [NUM_OPS-1:0]         w_snan;
   logic [NUM_OPS-1:0]         w_den;
   logic                       w_capture;

   logic                       r_valid;
   logic [NUM_OPS-1:0]         r_sign;
   logic [NUM_OPS*EXP_OW-1:0]  r_exp;
   logic [NUM_OPS*MANT_OW-1:0] r_mant;
   logic [NUM_OPS-1:0]         r_zero;
   logic [NUM_OPS-1:0]         r_inf;
   logic [NUM_OPS-1:0]         r_nan;
   logic [NUM_OPS-1:0]         r_snan;
   logic [NUM_OPS-1:0]         r_den;
   logic [TAG_W-1:0]           r_tag;

   // Per-operand decode; channels are fully independent
   for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
      logic [C_EXP_W-1:0]  w_e;
      logic [C_MANT_W-1:0] w_f;
      logic                w_e_zero;
      logic                w_e_ones;
      logic                w_f_zero;
      logic [LZ_W-1:0]     w_lz;
      logic [LZ_W:0]       w_sh;
      logic [MANT_OW-1:0]  w_mant_norm;
      logic [EXP_OW-1:0]   w_exp_den;
      logic [EXP_OW-1:0]   w_exp_o;
      logic [MANT_OW-1:0]  w_mant_o;

      assign w_sign[g] = Operands_DI[g*OP_W + OP_W - 1];
      assign w_e       = Operands_DI[g*OP_W + C_MANT_W +: C_EXP_W];
      assign w_f       = Operands_DI[g*OP_W +: C_MANT_W];
      assign w_e_zero  = (w_e == '0);
      assign w_e_ones  = (w_e == '1);
      assign w_f_zero  = (w_f == '0);

      // Leading-zero count of the fraction, MSB first
      always_comb begin : p_lzc
         logic v_found;
         v_found = 1'b0;
         w_lz    = '0;
         for (int i = int'(C_MANT_W) - 1; i >= 0; i--) begin
            if (!v_found) begin
               if (w_f[i]) v_found = 1'b1;
               else        w_lz    = w_lz + LZ_W'(1);
            end
         end
      end

      // Shift past the leading zeros and one more so the MSB lands on the hidden bit
      assign w_sh        = {1'b0, w_lz} + (LZ_W+1)'(1);
      assign w_mant_norm = MANT_OW'({1'b0, w_f} << w_sh);
      assign w_exp_den   = EXP_OW'(0) - EXP_OW'(w_lz);

      always_comb begin
         w_exp_o  = EXP_OW'(w_e);
         w_mant_o = {1'b1, w_f};
         if (w_e_zero) begin
            if (w_f_zero) begin
               w_exp_o  = '0;
               w_mant_o = '0;
            end else if (NORM_DEN != 0) begin
               w_exp_o  = w_exp_den;
               w_mant_o = w_mant_norm;
            end else begin
               w_exp_o  = EXP_OW'(1);
               w_mant_o = {1'b0, w_f};
            end
         end
      end

      assign w_exp[g*EXP_OW +: EXP_OW]    = w_exp_o;
      assign w_mant[g*MANT_OW +: MANT_OW] = w_mant_o;
      assign w_zero[g] = w_e_zero & w_f_zero;
      assign w_den[g]  = w_e_zero & ~w_f_zero;
      assign w_inf[g]  = w_e_ones & w_f_zero;
      assign w_nan[g]  = w_e_ones & ~w_f_zero;
      assign w_snan[g] = w_e_ones & ~w_f_zero & ~w_f[C_MANT_W-1];
   end

   assign In_ready_SO = ~r_valid | Out_ready_SI;
   assign w_capture   = In_valid_SI & In_ready_SO & ~Flush_SI;

   // Valid flag: flush wins, then capture, then drain
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         r_valid <= 1'b0;
      end else if (Flush_SI) begin
         r_valid <= 1'b0;
      end else if (w_capture) begin
         r_valid <= 1'b1;
      end else if (Out_ready_SI) begin
         r_valid <= 1'b0;
      end
   end

   // Payload registers load only on capture
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         r_sign <= '0;
         r_exp  <= '0;
         r_mant <= '0;
         r_zero <= '0;
         r_inf  <= '0;
         r_nan  <= '0;
         r_snan <= '0;
         r_den  <= '0;
         r_tag  <= '0;
      end else if (w_capture) begin
         r_sign <= w_sign;
         r_exp  <= w_exp;
         r_mant <= w_mant;
         r_zero <= w_zero;
         r_inf  <= w_inf;
         r_nan  <= w_nan;
         r_snan <= w_snan;
         r_den  <= w_den;
         r_tag  <= Tag_DI;
      end
   end

   assign Out_valid_SO = r_valid;
   assign Sign_DO      = r_sign;
   assign Exp_DO       = r_exp;
   assign Mant_DO      = r_mant;
   assign Zero_SO      = r_zero;
   assign Inf_SO       = r_inf;
   assign NaN_SO       = r_nan;
   assign SNaN_SO      = r_snan;
   assign DeN_SO       = r_den;
   assign Tag_DO       = r_tag;

endmodule
